// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and helpers for the instruction memory responder
package imem_pkg;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } imem_rsp_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic        err;
  } imem_stage_t;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  // Word index compared in full 32-bit space so high addresses never alias.
  function automatic logic word_in_range(input logic [31:0] addr, input int depth);
    logic [31:0] lim;
    lim = 32'(depth);
    return {2'b00, addr[31:2]} < lim;
  endfunction

  function automatic logic addr_err(input logic [31:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || !word_in_range(addr, depth);
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// rtl/imem_rsp_fifo.sv - synchronous FIFO, registered head, no fall-through
module imem_rsp_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      fill;
  logic             do_push;
  logic             do_pop;

  assign full    = (fill == (AW+1)'(DEPTH));
  assign empty   = (fill == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - pipelined instruction fetch responder with flush and load port
module imem_responder #(
  parameter int          DEPTH_WORDS     = 1024,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] NOP_WORD        = imem_pkg::NOP_WORD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        busy
);

  import imem_pkg::*;

  localparam int IW = idx_width(DEPTH_WORDS);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic [31:0]  mem [DEPTH_WORDS];
  imem_stage_t  pipe [LATENCY];
  logic [CW-1:0] count;
  logic         accept;
  logic         pop;
  logic         fifo_empty;
  logic         fifo_full;
  imem_rsp_t    push_rsp;
  imem_rsp_t    head_rsp;
  logic [31:0]  last_addr;
  logic         unused;

  assign unused    = ^{ld_addr[1:0], fifo_full};
  assign req_ready = (count < CW'(MAX_OUTSTANDING)) && !flush && !ld_en;
  assign accept    = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (count != '0);

  // Count spans pipeline and FIFO, so a full FIFO can never be pushed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      count <= '0;
    else if (flush) count <= '0;
    else            count <= count + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: accept, addr: req_addr, err: addr_err(req_addr, DEPTH_WORDS)};
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      if (flush) begin
        for (int i = 0; i < LATENCY; i++) pipe[i].valid <= 1'b0;
      end
    end
  end

  // Read happens combinationally in the final stage, so a same-edge load is seen next time.
  assign last_addr = pipe[LATENCY-1].addr;
  always_comb begin
    push_rsp       = '0;
    push_rsp.addr  = last_addr;
    push_rsp.err   = pipe[LATENCY-1].err;
    push_rsp.instr = pipe[LATENCY-1].err ? NOP_WORD : mem[last_addr[IW+1:2]];
  end

  always_ff @(posedge clock) begin
    if (ld_en && word_in_range(ld_addr, DEPTH_WORDS)) mem[ld_addr[IW+1:2]] <= ld_data;
  end

  imem_rsp_fifo #(
    .WIDTH ($bits(imem_rsp_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (pipe[LATENCY-1].valid),
    .push_data (push_rsp),
    .pop       (pop),
    .clear     (flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_rsp)
  );

  assign rsp_valid = !fifo_empty;
  assign rsp_instr = fifo_empty ? NOP_WORD : head_rsp.instr;
  assign rsp_addr  = fifo_empty ? 32'h0    : head_rsp.addr;
  assign rsp_err   = fifo_empty ? 1'b0     : head_rsp.err;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder
module tb_imem_responder;
  import imem_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        busy;

  int errors = 0;
  int checks = 0;
  imem_rsp_t sb[$];

  localparam logic [31:0] W0  = 32'h0050_0093;
  localparam logic [31:0] W1  = 32'h0010_0113;
  localparam logic [31:0] W2  = 32'h0020_0193;
  localparam logic [31:0] NOP = 32'h0000_0013;

  imem_responder dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got addr %h instr %h expected no response", rsp_addr, rsp_instr);
      end else begin
        imem_rsp_t e;
        e = sb.pop_front();
        chk("rsp_instr", rsp_instr, e.instr);
        chk("rsp_addr", rsp_addr, e.addr);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      end
    end
  end

  task automatic req(input logic [31:0] a, input logic [31:0] ei, input logic ee);
    bit ok;
    int n;
    ok = 0;
    n = 0;
    req_valid = 1'b1;
    req_addr = a;
    while (!ok && n < 50) begin
      @(negedge clock);
      if (req_ready) begin
        ok = 1;
        sb.push_back('{instr: ei, addr: a, err: ee});
      end
      @(posedge clock);
      #1;
      n++;
    end
    req_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no accept expected accept of %h", a);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clock);
    chk("ready_during_load", {31'b0, req_ready}, 32'd0);
    @(posedge clock);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clock);
      #2;
      done = (sb.size() == 0) && !busy;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  // Called right after a lone request is accepted into an empty responder.
  task automatic lat_check(input string name);
    @(negedge clock);
    @(negedge clock);
    chk({name, "_early"}, {31'b0, rsp_valid}, 32'd0);
    @(negedge clock);
    chk({name, "_on_time"}, {31'b0, rsp_valid}, 32'd1);
  endtask

  initial begin
    int accepted;
    reset = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    flush = 1'b0;
    rsp_ready = 1'b0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    #3;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_instr", rsp_instr, NOP);
    chk("rst_rsp_addr", rsp_addr, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // back-to-back fetch with latency check
    load(32'h0, W0);
    load(32'h4, W1);
    rsp_ready = 1'b1;
    req(32'h0, W0, 1'b0);
    req(32'h4, W1, 1'b0);
    @(negedge clock);
    chk("b2b_early", {31'b0, rsp_valid}, 32'd0);
    @(negedge clock);
    chk("b2b_first", {31'b0, rsp_valid}, 32'd1);
    @(negedge clock);
    chk("b2b_second", {31'b0, rsp_valid}, 32'd1);
    @(negedge clock);
    chk("b2b_done", {31'b0, rsp_valid}, 32'd0);
    drain();

    // backpressure: only four accepted
    @(posedge clock);
    #1;
    rsp_ready = 1'b0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1;
      req_addr = (k % 2 == 1) ? 32'h4 : 32'h0;
      @(negedge clock);
      if (k >= 4) chk("ready_when_full", {31'b0, req_ready}, 32'd0);
      if (req_ready) begin
        accepted++;
        sb.push_back('{instr: (k % 2 == 1) ? W1 : W0, addr: req_addr, err: 1'b0});
      end
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    chk("accepted", accepted, 32'd4);
    @(negedge clock);
    chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp_instr", rsp_instr, W0);
    @(negedge clock);
    chk("bp_instr_stable", rsp_instr, W0);
    chk("bp_addr_stable", rsp_addr, 32'h0);
    @(posedge clock);
    #1;
    rsp_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("ready_after_pop", {31'b0, req_ready}, 32'd1);
    drain();

    // misaligned and out of range
    req(32'h2, NOP, 1'b1);
    req(32'h1000, NOP, 1'b1);
    drain();

    // flush with requests in flight
    rsp_ready = 1'b0;
    req(32'h0, W0, 1'b0);
    req(32'h4, W1, 1'b0);
    req(32'h0, W0, 1'b0);
    flush = 1'b1;
    req_valid = 1'b1;
    req_addr = 32'h8;
    @(negedge clock);
    chk("ready_in_flush", {31'b0, req_ready}, 32'd0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    req_valid = 1'b0;
    sb.delete();
    @(negedge clock);
    chk("flush_busy", {31'b0, busy}, 32'd0);
    chk("flush_valid", {31'b0, rsp_valid}, 32'd0);
    rsp_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    req(32'h4, W1, 1'b0);
    lat_check("post_flush");
    drain();

    // load collides with final-stage read of the same word
    load(32'h8, W2);
    rsp_ready = 1'b1;
    req(32'h8, W2, 1'b0);
    @(posedge clock);
    #1;
    ld_en = 1'b1;
    ld_addr = 32'h8;
    ld_data = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("ready_collide_load", {31'b0, req_ready}, 32'd0);
    @(posedge clock);
    #1;
    ld_en = 1'b0;
    drain();
    req(32'h8, 32'hDEAD_BEEF, 1'b0);
    drain();

    // asynchronous reset with responses queued
    rsp_ready = 1'b0;
    req(32'h0, W0, 1'b0);
    req(32'h4, W1, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("pre_reset_valid", {31'b0, rsp_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("arst_rsp_instr", rsp_instr, NOP);
    chk("arst_rsp_addr", rsp_addr, 32'd0);
    chk("arst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_reset_quiet", {31'b0, rsp_valid}, 32'd0);
    end
    @(posedge clock);
    #1;
    req(32'h4, W1, 1'b0);
    lat_check("post_reset");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Responder side of the instruction-fetch interface. The fetch unit issues word addresses; this block returns the instruction word at each address, in order, after a fixed pipelined latency.
- Holds a word-addressed instruction array, preloaded through a separate load port by the testbench or boot loader.
- Replaces the zero-latency combinational instruction memory so the fetch path can be exercised with realistic latency, backpressure and redirect (flush).

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array. Power of two.
- LATENCY, 2: cycles from request acceptance to earliest rsp_valid. Must be >= 1.
- MAX_OUTSTANDING, 4: maximum requests in flight (pipeline plus response FIFO). Power of two.
- NOP_WORD, 32'h00000013: instruction returned on error and after reset.

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: fetch request valid.
- req_ready, output, 1: responder can accept a request.
- req_addr, input, 32: byte address of the fetch.
- flush, input, 1: drop all in-flight requests and responses (branch redirect).
- rsp_valid, output, 1: response valid.
- rsp_ready, input, 1: fetch side accepts the response.
- rsp_instr, output, 32: fetched instruction.
- rsp_addr, output, 32: byte address the response belongs to.
- rsp_err, output, 1: misaligned or out-of-range access.
- ld_en, input, 1: write one word into the array.
- ld_addr, input, 32: byte address for the load; bits [1:0] are ignored.
- ld_data, input, 32: word to write.
- busy, output, 1: at least one request in flight.

Behaviour:
- Reset (asynchronous):
  - Pipeline valid bits and FIFO are cleared; outstanding count = 0.
  - rsp_valid = 0, rsp_instr = NOP_WORD, rsp_addr = 0, rsp_err = 0, busy = 0.
  - Array contents are not reset.
  - Reset asserted mid-operation discards everything in flight; no response is produced after reset releases.
- Accept: a request is accepted when req_valid && req_ready.
  - req_ready = (count < MAX_OUTSTANDING) && !flush && !ld_en. Combinational from count and those inputs, so it is 1 right after reset.
- Count: count = pipeline entries + FIFO entries; width clog2(MAX_OUTSTANDING)+1.
  - Each cycle: count_next = count + accept − pop, where pop = rsp_valid && rsp_ready.
  - Because the count covers the pipeline, the FIFO can never overflow. No drop path exists.
- Pipeline: LATENCY-stage shift register carrying {valid, addr, err}.
  - err = (addr[1:0] != 0) || (addr[31:2] >= DEPTH_WORDS).
  - On the final stage the array is read at addr[clog2(DEPTH_WORDS)+1:2]. The instr field is NOP_WORD if err is set.
  - The result is pushed into the response FIFO (depth MAX_OUTSTANDING) in the same cycle.
- Response timing: the FIFO head drives rsp_*.
  - With an empty FIFO, a request accepted at edge T gives rsp_valid high in cycle T+LATENCY.
  - Full throughput is 1 request per cycle when rsp_ready is held high.
  - Responses return in request order.
- Backpressure: while rsp_valid && !rsp_ready, rsp_instr, rsp_addr and rsp_err stay stable.
- FIFO simultaneous events:
  - Push and pop in the same cycle are both legal.
  - Push into an empty FIFO is not visible until the next cycle; no fall-through.
- Flush (synchronous, single cycle):
  - All pipeline valid bits and the FIFO are cleared at the edge; count becomes 0.
  - A pop coincident with flush still counts as delivered to the fetch side.
  - No request is accepted in the flush cycle.
  - rsp_valid = 0 in the cycle after flush.
- Load:
  - ld_en writes ld_data to word ld_addr[clog2(DEPTH_WORDS)+1:2] at the edge.
  - Out-of-range ld_addr is ignored.
  - req_ready is low during ld_en.
  - If a pipeline read of the same word occurs in the same cycle, it returns the old data (read-before-write).
- busy = (count != 0).
- Address arithmetic: 32-bit, no wrap. Addresses >= DEPTH_WORDS*4 are errors, not aliases.

Decomposition:
- Shared package imem_pkg holds:
  - NOP_WORD constant.
  - Word-index width function (clog2).
  - Response struct {instr[31:0], addr[31:0], err}, shared with the fetch unit.
- One natural sub-module: imem_rsp_fifo, a synchronous FIFO.
  - Parameters: width and depth.
  - Ports: push, pop, clear, full, empty, head data.
  - Instantiated once for the response queue.

Test Plan:
- Load words 0x00500093 at 0x0 and 0x00100113 at 0x4, rsp_ready=1, request 0x0 then 0x4 back-to-back:
  - rsp_valid at cycles T+2 and T+3.
  - rsp_instr 0x00500093 then 0x00100113.
  - rsp_addr 0x0 then 0x4; rsp_err=0.
- rsp_ready=0, issue 6 consecutive requests:
  - Exactly 4 accepted; req_ready=0 after the 4th.
  - Then rsp_ready=1 drains 4 in-order responses; req_ready returns once count drops below 4.
- Request 0x2 (misaligned), then 0x1000 (out of range, DEPTH_WORDS=1024):
  - Both responses have rsp_err=1 and rsp_instr=0x00000013.
- 3 requests in flight, flush pulsed while req_valid=1:
  - req_ready=0 in the flush cycle.
  - No responses from the flushed requests ever appear; busy=0 the next cycle.
  - A new request to 0x4 returns 0x00100113 after 2 cycles.
- ld_en to 0x8 with data 0xDEADBEEF in the same cycle a pipelined read of 0x8 completes:
  - That response returns the old word.
  - A later request to 0x8 returns 0xDEADBEEF.
  - req_ready=0 during ld_en.
- Assert reset with 2 responses queued and rsp_valid=1:
  - Outputs go to their reset values immediately (asynchronously).
  - After release, rsp_valid stays 0 until a new request completes.
